// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types and constants for the LCD character scheduler:
//            output FSM states, displayable ASCII ranges, default sizing.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_DEPTH_DEFAULT      = 8;
    localparam int LCD_GAP_CYCLES_DEFAULT = 4;

    // Only space, digits and upper-case letters reach the display
    localparam logic [7:0] CHAR_SPACE    = 8'h20;
    localparam logic [7:0] CHAR_DIGIT_LO = 8'h30;
    localparam logic [7:0] CHAR_DIGIT_HI = 8'h39;
    localparam logic [7:0] CHAR_UPPER_LO = 8'h41;
    localparam logic [7:0] CHAR_UPPER_HI = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } lcd_state_e;

    function automatic logic is_displayable(input logic [7:0] c);
        return (c == CHAR_SPACE) ||
               ((c >= CHAR_DIGIT_LO) && (c <= CHAR_DIGIT_HI)) ||
               ((c >= CHAR_UPPER_LO) && (c <= CHAR_UPPER_HI));
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_fifo.sv
`default_nettype none
// ============================================================================
// Module   : char_fifo
// Brief    : DEPTH x WIDTH synchronous FIFO with wrap-around pointers,
//            synchronous clear and an occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still takes a push when the head leaves on the same edge
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_C) || do_pop);

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clock_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; clear dominates push/pop
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/lcd_char_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_scheduler
// Brief    : Round-robin merge of Morse and keyboard character streams into
//            a FIFO, filtered to displayable ASCII, drained to an LCD
//            controller with one-cycle strobes and a minimum idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_char_scheduler
    import lcd_pkg::*;
#(
    parameter int DEPTH      = LCD_DEPTH_DEFAULT,
    parameter int GAP_CYCLES = LCD_GAP_CYCLES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   morse_valid,
    input  logic [7:0]             morse_char,
    output logic                   morse_ready,
    input  logic                   key_valid,
    input  logic [7:0]             key_char,
    output logic                   key_ready,
    input  logic                   lcd_busy,
    output logic                   lcd_write_en,
    output logic [7:0]             lcd_char,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   dropped
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [7:0]       GAP_LAST_C = 8'(GAP_CYCLES - 1);

    lcd_state_e state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       write_en_q, write_en_d;
    logic [7:0] char_q, char_d;
    logic       dropped_q, dropped_d;
    logic       favour_key_q, favour_key_d;

    logic       not_full;
    logic       grant_morse;
    logic       grant_key;
    logic       accept;
    logic       accept_ok;
    logic [7:0] accept_char;
    logic       push;
    logic       pop;
    logic [7:0] fifo_head;

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .clear_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (accept_char),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Input arbitration: round-robin grant, gated by FIFO space (no bypass)
    always_comb begin
        not_full     = (fifo_count < DEPTH_C);
        grant_morse  = morse_valid && (!key_valid || !favour_key_q);
        grant_key    = key_valid && !grant_morse;
        morse_ready  = not_full && grant_morse;
        key_ready    = not_full && grant_key;
        accept       = morse_ready || key_ready;
        accept_char  = morse_ready ? morse_char : key_char;
        accept_ok    = is_displayable(accept_char);
        push         = accept && accept_ok && !clear;
        favour_key_d = morse_ready ? 1'b1 : (key_ready ? 1'b0 : favour_key_q);
        dropped_d    = clear ? 1'b0 : (dropped_q || (accept && !accept_ok));
    end

    // Output FSM: strobe the FIFO head, then hold off for the idle gap
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        write_en_d = 1'b0;
        char_d     = char_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((fifo_count != '0) && !lcd_busy) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                write_en_d = 1'b1;
                char_d     = fifo_head;
                pop        = 1'b1;
                gap_cnt_d  = 8'd0;
                state_d    = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q < GAP_LAST_C) begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end else if (!lcd_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d    = ST_IDLE;
            gap_cnt_d  = 8'd0;
            write_en_d = 1'b0;
            pop        = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= 8'd0;
            write_en_q   <= 1'b0;
            char_q       <= 8'h00;
            dropped_q    <= 1'b0;
            favour_key_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            write_en_q   <= write_en_d;
            char_q       <= char_d;
            dropped_q    <= dropped_d;
            favour_key_q <= favour_key_d;
        end
    end

    assign lcd_write_en = write_en_q;
    assign lcd_char     = char_q;
    assign dropped      = dropped_q;

endmodule
`default_nettype wire

// File: doc/lcd_char_scheduler.md
LCD_CHAR_SCHEDULER -- requirements
Module: lcd_char_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 4, meaning minimum idle cycles after each LCD write strobe (1..255).
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1, meaning synchronous flush of FIFO and sticky flags.
REQ-006 SHALL have port morse_valid, input, 1, meaning the decoded-Morse character is offered.
REQ-007 SHALL have port morse_char, input, 8, meaning the ASCII code from the processor decode path.
REQ-008 SHALL have port morse_ready, output, 1, meaning the Morse character is accepted this cycle.
REQ-009 SHALL have port key_valid, input, 1, meaning the PS/2-derived character is offered.
REQ-010 SHALL have port key_char, input, 8, meaning the ASCII code from ps2toascii.
REQ-011 SHALL have port key_ready, output, 1, meaning the key character is accepted this cycle.
REQ-012 SHALL have port lcd_busy, input, 1, meaning the LCD controller cannot take a character.
REQ-013 SHALL have port lcd_write_en, output, 1, meaning a one-cycle write strobe to the LCD controller.
REQ-014 SHALL have port lcd_char, output, 8, meaning the character presented with lcd_write_en.
REQ-015 SHALL have port fifo_count, output, $clog2(DEPTH)+1, meaning current occupancy.
REQ-016 SHALL have port dropped, output, 1, meaning a sticky flag for a filtered (non-displayable) character.

Function
REQ-017 SHALL accept a character only when valid and ready are both high on the same edge.
REQ-018 SHALL drive ready = (fifo_count < DEPTH) AND grant to that requester; the decision is combinational from registered state and the valids.
REQ-019 SHALL arbitrate round-robin: when both valids are high, grant the requester not granted most recently; after reset, Morse has priority.
REQ-020 SHALL grant at most one requester per cycle; a lone requester is granted whenever the FIFO is not full.
REQ-021 SHALL accept a character but not push it if it is outside 0x20, 0x30-0x39, 0x41-0x5A; in that case it sets dropped.
REQ-022 SHALL implement the FIFO with wrap-around pointers; a push and a pop on the same edge leave fifo_count unchanged.
REQ-023 SHALL accept a push while the FIFO is full only if a pop occurs on the same edge; ready stays low when full (no bypass).
REQ-024 SHALL run an output FSM with states IDLE, ISSUE, GAP.
REQ-025 SHALL go IDLE->ISSUE when fifo_count>0 and lcd_busy=0.
REQ-026 SHALL, in ISSUE, register lcd_write_en=1 for exactly one cycle with lcd_char = FIFO head, pop, and go to GAP.
REQ-027 SHALL, in GAP, count GAP_CYCLES cycles, then go to IDLE only when lcd_busy=0; otherwise remain in GAP.
REQ-028 SHALL give a latency from accept on edge N to lcd_write_en high after edge N+2 when the FSM is IDLE and lcd_busy=0.
REQ-029 SHALL hold lcd_char stable from the strobe until the next ISSUE.
REQ-030 SHALL, on clear, empty the FIFO, zero dropped, force IDLE, and deassert lcd_write_en on the next edge; clear has priority over a simultaneous push.

Reset
REQ-031 SHALL, on reset, asynchronously set the FIFO to empty, fifo_count=0, lcd_write_en=0, lcd_char=0x00, dropped=0, FSM=IDLE, gap counter=0, round-robin pointer=Morse.
REQ-032 SHALL, when reset occurs mid-ISSUE or mid-GAP, abort with no further strobe; the first post-reset strobe is no earlier than the second edge after release.

Structure
REQ-033 SHALL place the FSM state enum, the displayable-range constants (0x20, 0x30, 0x39, 0x41, 0x5A), and the default DEPTH/GAP_CYCLES in the shared package lcd_pkg.
REQ-034 SHALL contain one sub-module, char_fifo (parameterized DEPTH x 8, push/pop/clear, count output).
REQ-035 SHALL register all outputs except morse_ready and key_ready.

Verification
REQ-036 SHALL cover: single Morse 0x41, lcd_busy=0 -> lcd_write_en pulse 1 cycle, lcd_char=0x41, two edges after accept.
REQ-037 SHALL cover: both valids held with Morse 0x45 and key 0x31 for 4 cycles -> push order 0x45,0x31,0x45,0x31.
REQ-038 SHALL cover: DEPTH+2 pushes with lcd_busy=1 -> fifo_count=8, both readys low, no strobe; release busy -> 8 strobes, each followed by >=4 idle cycles.
REQ-039 SHALL cover: key_char=0x0A -> accepted, not pushed, dropped=1, fifo_count unchanged; clear -> dropped=0.
REQ-040 SHALL cover: push and pop on the same edge at fifo_count=3 -> fifo_count stays 3.
REQ-041 SHALL cover: reset asserted in GAP with 3 entries -> outputs at reset values immediately, no strobe, fifo_count=0.
